if_fetch_unit: RTL and testbench

Instruction-fetch control stage for the 8-bit pipelined RISC core; sits directly downstream of the program counter register.
- Reads the current PC, issues word-addressed reads to the synchronous instruction memory, and steers the PC's next value and enable.
- Queues returned instructions in a 2-entry buffer that forms the IF/ID boundary.
- Absorbs decode stalls without losing instructions.
- Handles branch/jump redirects from execute by flushing everything in flight.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 50 +++++
 rtl/if_fetch_unit.sv | 95 +++++++++
 tb/tb_if_fetch_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package fetch_pkg;

  localparam int         INSTR_W_DEF   = 16;
  localparam logic [7:0] RESET_VEC_DEF = 8'h00;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [7:0]             pc;
  } fetch_entry_t;

  // The 8-bit PC wraps from FF back to 00.
  function automatic logic [7:0] pc_incr(input logic [7:0] pc);
    return pc + 8'd1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry IF/ID buffer: push/pop/flush, head visible combinationally, no bypass.
module fetch_fifo #(
  parameter int DATA_W = 24
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic              do_pop;

  assign do_pop = pop && (count != 2'd0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      // NOTE: the storage is reset as well, so the head reads zero out of reset
      // instead of X; use <= only in clocked blocks so every read sees pre-edge values.
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(do_pop);
    end
  end

  // The credit check upstream guarantees a full buffer is never written.
  push_into_full: assert property (@(posedge CLK) disable iff (!RST_n)
                                   !(push && count == 2'd2));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch control: drives the PC, issues imem reads, buffers
// returned instructions for decode and flushes everything on a redirect.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter int         INSTR_W   = INSTR_W_DEF,
  parameter logic [7:0] RESET_VEC = RESET_VEC_DEF
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic [7:0]         PC_cur,
  output logic [7:0]         PC_next,
  output logic               PC_en,
  output logic               Imem_rd,
  output logic [7:0]         Imem_addr,
  input  logic [INSTR_W-1:0] Imem_data,
  input  logic               Redirect,
  input  logic [7:0]         Redirect_target,
  input  logic               Stall,
  output logic               Id_valid,
  output logic [INSTR_W-1:0] Id_instr,
  output logic [7:0]         Id_pc
);

  fetch_state_t       state;
  logic               inflight;
  logic [7:0]         inflight_pc;
  logic [1:0]         count;
  logic [INSTR_W+7:0] head;
  logic [2:0]         occupancy;
  logic               pop;
  logic               push;
  logic               flush;
  logic               issue;

  assign Id_valid  = (count != 2'd0);
  assign Id_instr  = head[INSTR_W+7:8];
  assign Id_pc     = head[7:0];
  assign Imem_addr = PC_cur;

  assign pop   = Id_valid && !Stall;
  assign flush = (state == RUN) && Redirect;
  assign push  = inflight && !Redirect;

  // Entries that will be held after this cycle if nothing new is issued;
  // a new read is only allowed when its response is guaranteed a slot.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == RUN) && !Redirect && (occupancy < 3'd2);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    PC_en   = 1'b0;
    PC_next = PC_cur;
    Imem_rd = 1'b0;
    if (RST_n) begin
      if (state == BOOT) begin
        PC_en   = 1'b1;
        PC_next = RESET_VEC;
      end else if (Redirect) begin
        PC_en   = 1'b1;
        PC_next = Redirect_target;
      end else if (issue) begin
        PC_en   = 1'b1;
        Imem_rd = 1'b1;
        PC_next = pc_incr(PC_cur);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state       <= BOOT;
      inflight    <= 1'b0;
      inflight_pc <= 8'h00;
    end else begin
      state    <= RUN;
      inflight <= issue;
      if (issue) inflight_pc <= PC_cur;
    end
  end

  fetch_fifo #(
    .DATA_W (INSTR_W + 8)
  ) u_fifo (
    .CLK       (CLK),
    .RST_n     (RST_n),
    .push      (push),
    .push_data ({Imem_data, inflight_pc}),
    .pop       (pop),
    .flush     (flush),
    .count     (count),
    .head      (head)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: PC register and synchronous imem modelled here,
// a queue-based reference checked every cycle, plus directed literal checks.
module tb_if_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pc_reg = 8'h55;
  logic [7:0]  pc_next;
  logic        pc_en;
  logic        imem_rd;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data = 16'hBAD0;
  logic        redirect;
  logic [7:0]  target;
  logic        stall;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [7:0]  id_pc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .CLK             (clk),
    .RST_n           (rst_n),
    .PC_cur          (pc_reg),
    .PC_next         (pc_next),
    .PC_en           (pc_en),
    .Imem_rd         (imem_rd),
    .Imem_addr       (imem_addr),
    .Imem_data       (imem_data),
    .Redirect        (redirect),
    .Redirect_target (target),
    .Stall           (stall),
    .Id_valid        (id_valid),
    .Id_instr        (id_instr),
    .Id_pc           (id_pc)
  );

  // Upstream PC register and memory holding instr = A000 + addr.
  always @(posedge clk) begin
    if (pc_en) pc_reg <= pc_next;
    imem_data <= imem_rd ? (16'hA000 + {8'h00, imem_addr}) : 16'hBAD0;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: instructions waiting for decode, plus at most one read whose data is due.
  fetch_entry_t m_q[$];
  bit           m_boot = 1'b1;
  bit           m_pend = 1'b0;
  logic [7:0]   m_pend_pc = 8'h00;

  always @(negedge clk) begin : model
    bit         exp_valid, exp_en, exp_rd, m_pop, m_issue;
    logic [7:0] exp_next;
    int         occ;
    if (!rst_n) begin
      check("rst_id_valid", 32'(id_valid), 32'd0);
      check("rst_id_pc", 32'(id_pc), 32'd0);
      check("rst_id_instr", 32'(id_instr), 32'd0);
      check("rst_pc_en", 32'(pc_en), 32'd0);
      check("rst_imem_rd", 32'(imem_rd), 32'd0);
      m_boot = 1'b1;
      m_q.delete();
      m_pend = 1'b0;
    end else begin
      exp_valid = (m_q.size() != 0);
      check("m_id_valid", 32'(id_valid), 32'(exp_valid));
      if (exp_valid) begin
        check("m_id_pc", 32'(id_pc), 32'(m_q[0].pc));
        check("m_id_instr", 32'(id_instr), 32'(m_q[0].instr));
      end
      check("m_imem_addr", 32'(imem_addr), 32'(pc_reg));
      if (m_boot) begin
        exp_en = 1'b1; exp_rd = 1'b0; exp_next = RESET_VEC_DEF;
        m_boot = 1'b0;
      end else if (redirect) begin
        exp_en = 1'b1; exp_rd = 1'b0; exp_next = target;
        m_q.delete();
        m_pend = 1'b0;
      end else begin
        m_pop   = exp_valid && !stall;
        occ     = m_q.size() + int'(m_pend) - int'(m_pop);
        m_issue = (occ < 2);
        exp_en   = m_issue;
        exp_rd   = m_issue;
        exp_next = m_issue ? 8'(pc_reg + 8'd1) : pc_reg;
        if (m_pop) void'(m_q.pop_front());
        if (m_pend) m_q.push_back('{instr: 16'hA000 + {8'h00, m_pend_pc}, pc: m_pend_pc});
        m_pend    = m_issue;
        m_pend_pc = pc_reg;
      end
      check("m_pc_en", 32'(pc_en), 32'(exp_en));
      check("m_imem_rd", 32'(imem_rd), 32'(exp_rd));
      check("m_pc_next", 32'(pc_next), 32'(exp_next));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] stall_pat = 16'b0110_1110_0100_1011;

  initial begin
    rst_n = 1'b0; redirect = 1'b0; target = 8'h00; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    // Cycle 0: BOOT loads the reset vector.
    #1;
    check("boot_pc_en", 32'(pc_en), 32'd1);
    check("boot_pc_next", 32'(pc_next), 32'h00);
    check("boot_imem_rd", 32'(imem_rd), 32'd0);
    tick(); #1;
    check("c1_pc", 32'(pc_reg), 32'h00);
    check("c1_imem_rd", 32'(imem_rd), 32'd1);
    tick(); #1;
    check("c2_id_valid", 32'(id_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      if (k != 0) begin tick(); #1; end else begin tick(); #1; end
      check("run_id_valid", 32'(id_valid), 32'd1);
      check("run_id_pc", 32'(id_pc), 32'(k));
      check("run_id_instr", 32'(id_instr), 32'h0000A000 + 32'(k));
    end
    tick();                                   // cycle 6
    // Stall five cycles starting with pc 04 on Id (cycles 7..11).
    tick(); stall = 1'b1; #1;
    check("stall_id_pc", 32'(id_pc), 32'h04);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      check("stall_hold_pc", 32'(id_pc), 32'h04);
      check("stall_no_rd", 32'(imem_rd), 32'd0);
    end
    tick(); stall = 1'b0; #1;                 // cycle 12
    check("resume_pc04", 32'(id_pc), 32'h04);
    check("resume_rd", 32'(imem_rd), 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick(); #1;
      check("resume_valid", 32'(id_valid), 32'd1);
      check("resume_pc", 32'(id_pc), 32'h04 + 32'(k));
    end
    // Cycle 16: stall to fill the buffer, cycle 17: redirect to 40.
    tick(); stall = 1'b1; #1;
    check("pre_redir_pc", 32'(id_pc), 32'h08);
    tick(); stall = 1'b0; redirect = 1'b1; target = 8'h40; #1;
    check("redir_pc_next", 32'(pc_next), 32'h40);
    check("redir_no_rd", 32'(imem_rd), 32'd0);
    tick(); redirect = 1'b0; #1;
    check("redir_t1_valid", 32'(id_valid), 32'd0);
    check("redir_t1_addr", 32'(imem_addr), 32'h40);
    check("redir_t1_rd", 32'(imem_rd), 32'd1);
    tick(); #1;
    check("redir_t2_valid", 32'(id_valid), 32'd0);
    tick(); #1;
    check("redir_t3_valid", 32'(id_valid), 32'd1);
    check("redir_t3_pc", 32'(id_pc), 32'h40);
    check("redir_t3_instr", 32'(id_instr), 32'h0000A040);
    tick();                                   // cycle 21
    // Cycle 22: redirect and stall together.
    tick(); redirect = 1'b1; stall = 1'b1; target = 8'h10; #1;
    check("rs_pc_next", 32'(pc_next), 32'h10);
    tick(); redirect = 1'b0; stall = 1'b0; #1;
    check("rs_t1_valid", 32'(id_valid), 32'd0);
    tick(); #1;
    check("rs_t2_valid", 32'(id_valid), 32'd0);
    tick(); #1;
    check("rs_t3_pc", 32'(id_pc), 32'h10);
    // Cycle 26: jump to FE to cross the PC wrap.
    tick(); redirect = 1'b1; target = 8'hFE; #1;
    tick(); redirect = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      check("wrap_valid", 32'(id_valid), 32'd1);
      check("wrap_pc", 32'(id_pc), 32'(8'(8'hFE + 8'(k))));
    end
    // Reset pulse mid-stream.
    tick(); rst_n = 1'b0; #1;
    check("mrst_valid_now", 32'(id_valid), 32'd0);
    check("mrst_pc_en", 32'(pc_en), 32'd0);
    for (int k = 0; k < 2; k++) begin
      tick(); #1;
      check("mrst_valid_low", 32'(id_valid), 32'd0);
    end
    tick(); rst_n = 1'b1; #1;
    check("mrst_boot_en", 32'(pc_en), 32'd1);
    check("mrst_boot_next", 32'(pc_next), 32'h00);
    tick();
    tick(); #1;
    check("mrst_c2_valid", 32'(id_valid), 32'd0);
    tick(); #1;
    check("mrst_c3_valid", 32'(id_valid), 32'd1);
    check("mrst_c3_pc", 32'(id_pc), 32'h00);
    // Irregular stall pattern, checked by the reference only.
    for (int k = 0; k < 16; k++) begin
      tick(); stall = stall_pat[k];
    end
    tick(); stall = 1'b0;
    repeat (6) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
